// File: rtl/pr_read_arbiter.sv
// pr_read_arbiter
// Shares one AXI read-address channel between N_REQ requesters (vertex
// stream, in-edge stream, PageRank-score reads). Each requester has a cap on
// outstanding single-beat reads so its streaming buffer is never overrun.
// R beats are steered back to their requester by rid.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_addr        per-requester request and line address
//   req_ready                 one-cycle grant pulse (request captured)
//   arid_m..arready_m         AXI AR channel (single beat, 8-byte size)
//   rid_m, rlast_m, rvalid_m  AXI R channel observation
//   rready_m                  always 1 (data is not buffered here)
//   resp_valid                per-requester R beat steering (combinational)
//   idle                      nothing pending and no reads outstanding
//   err                       sticky protocol error (bad rid / unexpected rlast)
module pr_read_arbiter #(
  parameter int N_REQ       = 3,
  parameter int ADDR_W      = 64,
  parameter int MAX_OUT     = 4,
  parameter int PR_PRIORITY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  output logic [N_REQ-1:0]        req_ready,
  output logic [15:0]             arid_m,
  output logic [ADDR_W-1:0]       araddr_m,
  output logic [7:0]              arlen_m,
  output logic [2:0]              arsize_m,
  output logic                    arvalid_m,
  input  logic                    arready_m,
  input  logic [15:0]             rid_m,
  input  logic                    rlast_m,
  input  logic                    rvalid_m,
  output logic                    rready_m,
  output logic [N_REQ-1:0]        resp_valid,
  output logic                    idle,
  output logic                    err
);

  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam bit HAS_PRIO = (PR_PRIORITY != 0) && (N_REQ > 1);
  // Round-robin set: everyone, or everyone except the priority requester.
  localparam int RR_N     = HAS_PRIO ? N_REQ - 1 : N_REQ;

  typedef enum logic {ARB, ISSUE} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [3:0]       out_cnt_q [N_REQ];
  logic [3:0]       out_cnt_d [N_REQ];
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] cnt_nz;
  logic [N_REQ-1:0] zero_last;
  logic             ar_fire;
  logic             rid_bad;
  logic             win_valid;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;

  assign arlen_m  = 8'd0;
  assign arsize_m = 3'b011;
  assign rready_m = 1'b1;

  assign ar_fire = arvalid_m & arready_m;
  assign rid_bad = rvalid_m && (rid_m >= 16'(N_REQ));

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_req
      logic inc;
      logic dec;
      assign addr_arr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
      assign resp_valid[gi] = rvalid_m && (rid_m == 16'(gi));
      assign elig[gi]       = req_valid[gi] && (out_cnt_q[gi] < 4'(MAX_OUT));
      assign cnt_nz[gi]     = (out_cnt_q[gi] != 4'd0);
      // rlast with nothing outstanding is an error and must not underflow.
      assign zero_last[gi]  = resp_valid[gi] && rlast_m && !cnt_nz[gi];
      assign inc            = ar_fire && (arid_m == 16'(gi));
      assign dec            = resp_valid[gi] && rlast_m && cnt_nz[gi];
      // inc and dec together cancel, leaving the count unchanged.
      assign out_cnt_d[gi]  = out_cnt_q[gi] + {3'd0, inc} - {3'd0, dec};
    end
  endgenerate

  // Winner selection. The round-robin scan runs from the farthest candidate
  // to the nearest so the first eligible one strictly after rr_ptr wins.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = '0;
    if (HAS_PRIO && elig[N_REQ-1]) begin
      win_valid = 1'b1;
      win_idx   = IDX_W'(N_REQ - 1);
    end else begin
      for (int k = RR_N; k >= 1; k--) begin
        cand = IDX_W'((int'(rr_ptr_q) + k) % RR_N);
        if (elig[cand]) begin
          win_valid = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB;
      rr_ptr_q  <= '0;
      arvalid_m <= 1'b0;
      araddr_m  <= '0;
      arid_m    <= '0;
      req_ready <= '0;
      err       <= 1'b0;
      for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= '0;
    end else begin
      req_ready <= '0;
      case (state_q)
        ARB: begin
          if (win_valid) begin
            araddr_m           <= addr_arr[win_idx];
            arid_m             <= 16'(win_idx);
            req_ready[win_idx] <= 1'b1;
            arvalid_m          <= 1'b1;
            if (int'(win_idx) < RR_N) rr_ptr_q <= win_idx;
            state_q            <= ISSUE;
          end
        end
        ISSUE: begin
          // Address and ID stay put until the slave accepts them.
          if (arready_m) begin
            arvalid_m <= 1'b0;
            state_q   <= ARB;
          end
        end
        default: state_q <= ARB;
      endcase
      err <= err | rid_bad | (|zero_last);
      for (int i = 0; i < N_REQ; i++) out_cnt_q[i] <= out_cnt_d[i];
    end
  end

  assign idle = (state_q == ARB) && !(|cnt_nz);

endmodule

// File: tb/tb_pr_read_arbiter.sv
module tb_pr_read_arbiter;

  localparam int MAXO = 4;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [63:0] addr [3];
  logic [191:0] req_addr;
  logic [2:0]  req_ready;
  logic [15:0] arid_m;
  logic [63:0] araddr_m;
  logic [7:0]  arlen_m;
  logic [2:0]  arsize_m;
  logic        arvalid_m;
  logic        arready_m;
  logic [15:0] rid_m;
  logic        rlast_m;
  logic        rvalid_m;
  logic        rready_m;
  logic [2:0]  resp_valid;
  logic        idle;
  logic        err;

  assign req_addr = {addr[2], addr[1], addr[0]};

  pr_read_arbiter #(.N_REQ(3), .ADDR_W(64), .MAX_OUT(MAXO), .PR_PRIORITY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .arid_m(arid_m), .araddr_m(araddr_m),
    .arlen_m(arlen_m), .arsize_m(arsize_m), .arvalid_m(arvalid_m),
    .arready_m(arready_m), .rid_m(rid_m), .rlast_m(rlast_m),
    .rvalid_m(rvalid_m), .rready_m(rready_m), .resp_valid(resp_valid),
    .idle(idle), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one AR may be in flight; grants happen only when none
  // is; outstanding reads are plain per-requester counts.
  logic        m_arvalid;
  logic [63:0] m_araddr;
  int          m_arid;
  logic [2:0]  m_ready;
  int          m_cnt [3];
  int          m_rr;
  logic        m_err;
  logic        m_fire;

  function automatic logic m_idle();
    return !m_arvalid && m_cnt[0] == 0 && m_cnt[1] == 0 && m_cnt[2] == 0;
  endfunction

  function automatic int oh_id(logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    int win;
    int c;
    win = -1;
    if (rst) begin
      m_arvalid = 0; m_araddr = 0; m_arid = 0; m_ready = 0;
      m_cnt = '{0, 0, 0}; m_rr = 0; m_err = 0; m_fire = 0;
      return;
    end
    m_fire  = m_arvalid && arready_m;
    m_ready = 0;
    if (!m_arvalid) begin
      if (req_valid[2] && m_cnt[2] < MAXO) win = 2;
      else
        for (int k = 1; k <= 2; k++) begin
          c = (m_rr + k) % 2;
          if (win < 0 && req_valid[c] && m_cnt[c] < MAXO) win = c;
        end
    end
    if (rvalid_m) begin
      if (rid_m >= 3) m_err = 1;
      else if (rlast_m) begin
        if (m_cnt[rid_m] == 0) m_err = 1;
        else m_cnt[rid_m]--;
      end
    end
    if (m_fire) begin
      m_cnt[m_arid]++;
      m_arvalid = 0;
    end
    if (win >= 0) begin
      m_arvalid = 1; m_araddr = addr[win]; m_arid = win;
      m_ready[win] = 1'b1;
      if (win < 2) m_rr = win;
    end
  endtask

  task automatic compare_all();
    chk("req_ready", 64'(req_ready), 64'(m_ready));
    chk("arvalid", 64'(arvalid_m), 64'(m_arvalid));
    chk("araddr", araddr_m, m_araddr);
    chk("arid", 64'(arid_m), 64'(m_arid));
    chk("idle", 64'(idle), 64'(m_idle()));
    chk("err", 64'(err), 64'(m_err));
  endtask

  // Responder: answers each handshake resp_delay edges later, one beat/cycle.
  int cyc = 0;
  int rq_due[$];
  int rq_id[$];
  bit resp_on = 0;
  bit rnd_beats = 0;
  int resp_delay = 2;

  task automatic step();
    logic [2:0] exp_rv;
    if (resp_on) begin
      rvalid_m = 0; rlast_m = 0; rid_m = 0;
      if (rq_due.size() > 0 && rq_due[0] <= cyc + 1) begin
        rvalid_m = 1; rlast_m = 1; rid_m = 16'(rq_id[0]);
        void'(rq_due.pop_front());
        void'(rq_id.pop_front());
      end else if (rnd_beats && $urandom_range(7) == 0) begin
        rvalid_m = 1; rlast_m = 0; rid_m = 16'($urandom_range(2));
      end
    end
    #1;
    exp_rv = (rvalid_m && rid_m < 3) ? (3'b001 << rid_m) : 3'b000;
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    @(posedge clk);
    model_step();
    cyc++;
    if (rst) begin
      rq_due.delete();
      rq_id.delete();
    end else if (m_fire && resp_on) begin
      rq_due.push_back(cyc + resp_delay);
      rq_id.push_back(m_arid);
    end
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1; req_valid = 0; rvalid_m = 0; rlast_m = 0; rid_m = 0; arready_m = 0;
    step();
    rst = 0;
  endtask

  typedef struct {
    logic        rv;
    logic [15:0] rid;
    logic        rl;
    logic [2:0]  exp_resp;
    logic        exp_err;
  } rvec_t;

  rvec_t vec [9];

  initial begin
    int q[$];
    int id, got, n, last_g;
    vec[0] = '{1'b1, 16'd0,     1'b0, 3'b001, 1'b0};
    vec[1] = '{1'b1, 16'd1,     1'b0, 3'b010, 1'b0};
    vec[2] = '{1'b1, 16'd2,     1'b0, 3'b100, 1'b0};
    vec[3] = '{1'b0, 16'd1,     1'b1, 3'b000, 1'b0};
    vec[4] = '{1'b1, 16'd5,     1'b1, 3'b000, 1'b1};
    vec[5] = '{1'b1, 16'd3,     1'b0, 3'b000, 1'b1};
    vec[6] = '{1'b1, 16'd1,     1'b1, 3'b010, 1'b1};
    vec[7] = '{1'b1, 16'd0,     1'b1, 3'b001, 1'b1};
    vec[8] = '{1'b1, 16'hFFFF,  1'b0, 3'b000, 1'b1};

    addr[0] = 64'h1000; addr[1] = 64'h2000; addr[2] = 64'h3000;
    m_arvalid = 0; m_araddr = 0; m_arid = 0; m_ready = 0;
    m_cnt = '{0, 0, 0}; m_rr = 0; m_err = 0; m_fire = 0;

    // Reset state
    do_reset();
    chk("rst_arvalid", 64'(arvalid_m), 0);
    chk("rst_araddr", araddr_m, 0);
    chk("rst_arid", 64'(arid_m), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_idle", 64'(idle), 1);
    chk("const_arlen", 64'(arlen_m), 0);
    chk("const_arsize", 64'(arsize_m), 3);
    chk("const_rready", 64'(rready_m), 1);
    $display("reset: arvalid=%0b idle=%0b err=%0b", arvalid_m, idle, err);

    // R-channel steering and error vectors, each from a fresh reset
    for (int i = 0; i < 9; i++) begin
      do_reset();
      rvalid_m = vec[i].rv; rid_m = vec[i].rid; rlast_m = vec[i].rl;
      step();
      chk($sformatf("tbl%0d_resp", i), 64'(resp_valid), 64'(vec[i].exp_resp));
      chk($sformatf("tbl%0d_err", i), 64'(err), 64'(vec[i].exp_err));
      $display("vec %0d: rv=%0b rid=%0d rl=%0b resp=%b err=%0b", i,
               vec[i].rv, vec[i].rid, vec[i].rl, resp_valid, err);
      rvalid_m = 0; rlast_m = 0;
    end

    // 1: requesters 0 and 1, answers 2 cycles after handshake
    do_reset();
    resp_on = 1; resp_delay = 2; req_valid = 3'b011; arready_m = 1;
    n = 0; last_g = -1; q.delete();
    for (int i = 0; i < 20; i++) begin
      step();
      id = oh_id(req_ready);
      if (id >= 0) begin
        $display("t1 grant id=%0d addr=%0h", id, araddr_m);
        chk("t1_addr", araddr_m, addr[id]);
        if (q.size() > 0) chk("t1_alt", 64'(id), 64'(1 - q[$]));
        if (last_g >= 0) chk("t1_gap", 64'(cyc - last_g), 2);
        q.push_back(id); last_g = cyc; n++;
      end
    end
    chk("t1_grants", 64'(n), 10);

    // 2: priority requester 2, then round robin once it drops
    do_reset();
    req_valid = 3'b111; arready_m = 1; q.delete();
    for (int i = 0; i < 30; i++) begin
      step();
      id = oh_id(req_ready);
      if (id >= 0) begin
        $display("t2 grant id=%0d addr=%0h", id, araddr_m);
        if (q.size() == 0) chk("t2_first_addr", araddr_m, 64'h3000);
        q.push_back(id);
        if (id == 2 && q.size() >= 4) req_valid[2] = 0;
      end
    end
    chk("t2_count", 64'(q.size() >= 10), 1);
    if (q.size() >= 10) begin
      for (int i = 0; i < 4; i++) chk("t2_prio", 64'(q[i]), 2);
      for (int i = 4; i < 10; i++) chk("t2_rr_not2", 64'(q[i] != 2), 1);
      for (int i = 5; i < 10; i++) chk("t2_rr_alt", 64'(q[i]), 64'(1 - q[i-1]));
    end
    resp_on = 0;

    // 3: outstanding cap for requester 0
    do_reset();
    req_valid = 3'b001; arready_m = 1; n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (req_ready[0]) n++;
    end
    $display("t3 grants before cap=%0d", n);
    chk("t3_cap", 64'(n), 4);
    chk("t3_not_idle", 64'(idle), 0);
    rvalid_m = 1; rid_m = 0; rlast_m = 1;
    step();
    rvalid_m = 0; rlast_m = 0; n = 0;
    if (req_ready[0]) n++;
    for (int i = 0; i < 10; i++) begin
      step();
      if (req_ready[0]) n++;
    end
    $display("t3 grants after one rlast=%0d", n);
    chk("t3_one_more", 64'(n), 1);

    // 4: AR stall for 5 cycles
    do_reset();
    addr[1] = 64'hABCD_0040; req_valid = 3'b010; arready_m = 0; got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      step();
      if (req_ready[1]) got = 1;
    end
    chk("t4_grant", 64'(got), 1);
    req_valid = 0;
    for (int i = 0; i < 5; i++) begin
      chk("t4_arvalid", 64'(arvalid_m), 1);
      chk("t4_addr", araddr_m, 64'hABCD_0040);
      chk("t4_id", 64'(arid_m), 1);
      if (i > 0) chk("t4_ready", 64'(req_ready), 0);
      step();
    end
    arready_m = 1;
    step();
    $display("t4 handshake after stall: arvalid=%0b", arvalid_m);
    chk("t4_done", 64'(arvalid_m), 0);

    // 5: bad rid
    do_reset();
    rvalid_m = 1; rid_m = 16'd5; rlast_m = 1;
    step();
    chk("t5_resp", 64'(resp_valid), 0);
    chk("t5_err", 64'(err), 1);
    rvalid_m = 0; rlast_m = 0;
    for (int i = 0; i < 3; i++) step();
    chk("t5_sticky", 64'(err), 1);
    chk("t5_idle", 64'(idle), 1);
    $display("t5 bad rid: err=%0b", err);

    // 6: reset mid-operation with counts {0:2, 1:1, 2:3}
    do_reset();
    got = 0;
    for (int i = 0; i < 60 && got == 0; i++) begin
      req_valid = (m_cnt[2] < 3) ? 3'b100 : (m_cnt[1] < 1) ? 3'b010 : 3'b001;
      arready_m = !(m_cnt[2] == 3 && m_cnt[1] == 1 && m_cnt[0] == 2);
      step();
      if (m_cnt[2] == 3 && m_cnt[1] == 1 && m_cnt[0] == 2 && arvalid_m) got = 1;
    end
    chk("t6_setup", 64'(got), 1);
    rst = 1; rvalid_m = 1; rid_m = 1; rlast_m = 1;
    step();
    rst = 0; rvalid_m = 0; rlast_m = 0; req_valid = 0;
    chk("t6_arvalid", 64'(arvalid_m), 0);
    chk("t6_idle", 64'(idle), 1);
    chk("t6_err", 64'(err), 0);
    $display("t6 reset mid-op: arvalid=%0b idle=%0b err=%0b", arvalid_m, idle, err);

    // Randomized traffic against the model
    resp_on = 1; rnd_beats = 1;
    for (int c = 0; c < 2000; c++) begin
      resp_delay = $urandom_range(1, 6);
      arready_m  = ($urandom_range(3) != 0);
      rst        = ($urandom_range(499) == 0);
      for (int i = 0; i < 3; i++)
        if (!req_valid[i] || m_ready[i]) begin
          req_valid[i] = ($urandom_range(2) == 0);
          addr[i] = {$urandom, $urandom} & ~64'h3F;
        end
      step();
    end
    $display("random phase: %0d cycles", 2000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
